// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 scan codes, parser command codes and FSM state codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_I     = 8'h43;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_G     = 8'h34;
  localparam logic [7:0] KEY_H     = 8'h33;
  localparam logic [7:0] KEY_Y     = 8'h35;
  localparam logic [7:0] KEY_N     = 8'h31;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_filter.sv
// ============================================================================
// Module   : ps2_filter
// Brief    : Synchronizes PS/2 lines, glitch-filters the clock, and emits a
//            one-cycle sample pulse on each filtered falling clock edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sample,
  output logic data
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             clk_s1;
  logic             clk_s2;
  logic             dat_s1;
  logic             dat_s2;
  logic             filt;
  logic             filt_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      cnt    <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      filt_d <= filt;
      // Any sample matching the current level restarts the run length.
      if (clk_s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= clk_s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sample = filt_d & ~filt;
  assign data   = dat_s2;

endmodule

`default_nettype wire

// File: rtl/ps2_frame_ctrl.sv
// ============================================================================
// Module   : ps2_frame_ctrl
// Brief    : PS/2 frame receiver delivering one clean make code per keypress
//            (prefix/break stripped) with FLAG strobe, ERR pulse and BUSY.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_frame_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATO,
  output logic       FLAG,
  output logic       EXT,
  output logic       ERR,
  output logic       BUSY
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  // The counter reads 0 in the cycle after a sample, so this value is reached
  // TIMEOUT_CYCLES-1 cycles after the sample pulse itself.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  logic            sample;
  logic            sdata;
  logic [2:0]      state;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            brk;
  logic            ext;
  logic            err_q;
  logic            timeout;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (CLK),
    .rst_n    (RST_N),
    .ps2_clk  (PS2_CLK),
    .ps2_data (PS2_DATA),
    .sample   (sample),
    .data     (sdata)
  );

  assign timeout = (state != ST_IDLE) && (to_cnt == TO_LAST) && !sample;
  assign ERR     = err_q | timeout;
  assign BUSY    = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      brk     <= 1'b0;
      ext     <= 1'b0;
      err_q   <= 1'b0;
      DATO    <= 8'h00;
      FLAG    <= 1'b0;
      EXT     <= 1'b0;
    end else begin
      FLAG  <= 1'b0;
      err_q <= 1'b0;

      if (state == ST_IDLE || sample) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sample && !sdata) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            if (sample) begin
              shift   <= {sdata, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (sample) begin
              par_bit <= sdata;
              state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (sample) begin
              if (sdata && odd_parity_ok(shift, par_bit)) begin
                state <= ST_CHECK;
                // Decoded on the stop-bit edge so results appear during CHECK.
                case (shift)
                  SC_E0: ext <= 1'b1;
                  SC_F0: brk <= 1'b1;
                  SC_00, SC_FF: begin
                    err_q <= 1'b1;
                    brk   <= 1'b0;
                    ext   <= 1'b0;
                  end
                  SC_AA, SC_FA: ;
                  default: begin
                    if (brk) begin
                      brk <= 1'b0;
                      ext <= 1'b0;
                    end else begin
                      DATO <= shift;
                      EXT  <= ext;
                      FLAG <= 1'b1;
                      ext  <= 1'b0;
                    end
                  end
                endcase
              end else begin
                err_q <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end
          ST_CHECK: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_ctrl.sv
// ============================================================================
// Module   : tb_ps2_frame_ctrl
// Brief    : Directed self-checking bench for ps2_frame_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_frame_ctrl;
  import ps2_pkg::*;

  localparam int T    = 200;
  localparam int F    = 8;
  localparam int HALF = 20;
  // Raw falling edge -> 2 sync + FILTER_LEN filter stages -> sample cycle.
  localparam int SAMPLE_LAT = 2 + F;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] dato;
  logic       flag;
  logic       ext;
  logic       err;
  logic       busy;

  int cyc       = 0;
  int fall_cyc  = 0;
  int flag_cnt  = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int flag_cyc  = -1;
  int err_cyc   = -1;
  int checks    = 0;
  int failures  = 0;
  int f0, e0;

  ps2_frame_ctrl #(
    .TIMEOUT_CYCLES (T),
    .FILTER_LEN     (F)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .DATO     (dato),
    .FLAG     (flag),
    .EXT      (ext),
    .ERR      (err),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flag) begin flag_cnt++; flag_cyc = cyc; end
    if (err)  begin err_cnt++;  err_cyc  = cyc; end
    if (flag && err) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    wait_cyc(5);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(3);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(9);
    end else begin
      wait_cyc(15);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par,
                            input int glitch_bit);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_bit);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input logic exp_ext,
                             input int glitch_bit);
    int fs, es;
    fs = flag_cnt;
    es = err_cnt;
    send_frame(b, 11, 1'b0, glitch_bit);
    wait_cyc(20);
    check_eq({tag, "_flag_cnt"}, flag_cnt - fs, 1);
    check_eq({tag, "_flag_cyc"}, flag_cyc, fall_cyc + SAMPLE_LAT + 1);
    check_eq({tag, "_dato"}, dato, b);
    check_eq({tag, "_ext"}, ext, exp_ext);
    check_eq({tag, "_err_cnt"}, err_cnt - es, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    wait_cyc(5);
    check_eq("rst_dato", dato, 0);
    check_eq("rst_flag", flag, 0);
    check_eq("rst_ext", ext, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Short low pulse on an idle line must not start a frame.
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check_eq("glitch_idle_busy", busy, 0);
    check_eq("glitch_idle_flags", flag_cnt + err_cnt, 0);

    frame_check("make_5a", KEY_ENTER, 1'b0, -1);

    f0 = flag_cnt;
    send_frame(SC_F0, 11, 1'b0, -1);
    send_frame(KEY_ENTER, 11, 1'b0, -1);
    wait_cyc(20);
    check_eq("break_5a_flag_cnt", flag_cnt - f0, 0);
    check_eq("break_5a_dato", dato, KEY_ENTER);

    send_frame(SC_E0, 11, 1'b0, -1);
    frame_check("ext_75", 8'h75, 1'b1, -1);

    f0 = flag_cnt;
    send_frame(SC_E0, 11, 1'b0, -1);
    send_frame(SC_F0, 11, 1'b0, -1);
    send_frame(8'h75, 11, 1'b0, -1);
    wait_cyc(20);
    check_eq("ext_break_flag_cnt", flag_cnt - f0, 0);
    check_eq("ext_break_dato", dato, 8'h75);
    frame_check("after_ext_break_1c", KEY_A, 1'b0, -1);

    f0 = flag_cnt;
    e0 = err_cnt;
    send_frame(KEY_I, 11, 1'b1, -1);
    wait_cyc(20);
    check_eq("parity_err_cnt", err_cnt - e0, 1);
    check_eq("parity_err_cyc", err_cyc, fall_cyc + SAMPLE_LAT + 1);
    check_eq("parity_flag_cnt", flag_cnt - f0, 0);
    check_eq("parity_busy", busy, 0);
    frame_check("parity_retry_43", KEY_I, 1'b0, -1);

    f0 = flag_cnt;
    e0 = err_cnt;
    send_frame(KEY_R, 5, 1'b0, -1);
    check_eq("timeout_busy_mid", busy, 1);
    wait_cyc(T + 20);
    check_eq("timeout_err_cnt", err_cnt - e0, 1);
    check_eq("timeout_err_cyc", err_cyc, fall_cyc + SAMPLE_LAT + T - 1);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_flag_cnt", flag_cnt - f0, 0);
    frame_check("timeout_retry_2d", KEY_R, 1'b0, -1);

    frame_check("glitch_mid_34", KEY_G, 1'b0, 3);

    e0 = err_cnt;
    send_frame(SC_E0, 11, 1'b0, -1);
    send_frame(SC_FF, 11, 1'b0, -1);
    wait_cyc(20);
    check_eq("overrun_err_cnt", err_cnt - e0, 1);
    frame_check("after_overrun_5a", KEY_ENTER, 1'b0, -1);

    send_frame(KEY_H, 5, 1'b0, -1);
    check_eq("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_dato", dato, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_flag", flag, 0);
    check_eq("rstmid_err", err, 0);
    check_eq("rstmid_ext", ext, 0);
    f0 = flag_cnt;
    e0 = err_cnt;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(T + 20);
    check_eq("rstmid_quiet", (flag_cnt - f0) + (err_cnt - e0), 0);
    frame_check("rst_retry_33", KEY_H, 1'b0, -1);

    f0 = flag_cnt;
    e0 = err_cnt;
    send_frame(SC_AA, 11, 1'b0, -1);
    wait_cyc(20);
    check_eq("bat_flag_cnt", flag_cnt - f0, 0);
    check_eq("bat_err_cnt", err_cnt - e0, 0);
    check_eq("bat_dato", dato, KEY_H);

    check_eq("flag_err_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
